// File: rtl/uop_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : uop_queue_if
// Brief    : Enqueue/dequeue handshake bundle for the decoded micro-op queue.
// Revision : 1.0 - initial release
// ============================================================================
interface uop_queue_if #(
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2,
    parameter int ITEM_W = 50
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      squash_shadow;
    logic [ENQ_W-1:0]          enq_valid;
    logic [ENQ_W*ITEM_W-1:0]   enq_item;
    logic                      enq_ready;
    logic [DEQ_W-1:0]          deq_valid;
    logic [DEQ_W*ITEM_W-1:0]   deq_item;
    logic [DEQ_W-1:0]          deq_killed;
    logic [DEQ_W-1:0]          deq_ready;
    logic [c_CNT_W-1:0]        count;

    // Producer/consumer side (decode + issue)
    modport master (
        output flush, squash_shadow, enq_valid, enq_item, deq_ready,
        input  enq_ready, deq_valid, deq_item, deq_killed, count
    );

    // Queue side
    modport slave (
        input  flush, squash_shadow, enq_valid, enq_item, deq_ready,
        output enq_ready, deq_valid, deq_item, deq_killed, count
    );
endinterface
`default_nettype wire

// File: rtl/uop_queue.sv
`default_nettype none
// ============================================================================
// Module   : uop_queue
// Brief    : Multi-lane in-order micro-op FIFO with flush and shadow squash.
// Revision : 1.0 - initial release
// ============================================================================
module uop_queue #(
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2,
    parameter int ITEM_W = 50
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    uop_queue_if.slave q
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_ENQ_CW = $clog2(ENQ_W + 1);
    localparam int c_DEQ_CW = $clog2(DEQ_W + 1);

    logic [ITEM_W-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]    r_kill;
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_enq_ready;
    logic [c_ENQ_CW-1:0] w_n_enq;
    logic [c_DEQ_CW-1:0] w_n_deq;
    logic                w_enq_run;
    logic                w_deq_run;
    logic [DEQ_W-1:0]    w_deq_valid;
    logic [DEPTH-1:0]    w_resident;
    logic [DEPTH-1:0]    w_enq_hit;
    logic [DEPTH-1:0]    w_kill_next;

    // Space check uses only the registered count; same-cycle dequeues never help.
    assign w_enq_ready = (c_CNT_W'(DEPTH) - r_count) >= c_CNT_W'(ENQ_W);

    always_comb begin
        w_n_enq   = '0;
        w_enq_run = w_enq_ready;
        for (int i = 0; i < ENQ_W; i++) begin
            w_enq_run = w_enq_run & q.enq_valid[i];
            if (w_enq_run) begin
                w_n_enq = w_n_enq + c_ENQ_CW'(1);
            end
        end
    end

    always_comb begin
        w_n_deq   = '0;
        w_deq_run = 1'b1;
        for (int i = 0; i < DEQ_W; i++) begin
            w_deq_run = w_deq_run & w_deq_valid[i] & q.deq_ready[i];
            if (w_deq_run) begin
                w_n_deq = w_n_deq + c_DEQ_CW'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < DEQ_W; i++) begin : g_deq_lane
            logic [c_PTR_W-1:0] w_idx;
            assign w_idx          = r_head + c_PTR_W'(i);
            assign w_deq_valid[i] = r_count > c_CNT_W'(i);
            assign q.deq_item[i*ITEM_W +: ITEM_W] = r_data[w_idx];
            assign q.deq_killed[i] = r_kill[w_idx] & w_deq_valid[i];
        end
    endgenerate

    always_comb begin
        w_enq_hit = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            if (c_ENQ_CW'(i) < w_n_enq) begin
                w_enq_hit[r_tail + c_PTR_W'(i)] = 1'b1;
            end
        end
    end

    // Squash only touches slots that were occupied before this edge.
    generate
        for (genvar j = 0; j < DEPTH; j++) begin : g_slot
            logic [c_PTR_W-1:0] w_off;
            assign w_off         = c_PTR_W'(j) - r_head;
            assign w_resident[j] = c_CNT_W'(w_off) < r_count;
            assign w_kill_next[j] = ~q.flush & ~w_enq_hit[j] &
                (r_kill[j] | (q.squash_shadow & w_resident[j] & r_data[j][0]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_kill  <= '0;
        end else if (q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_kill  <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_n_deq);
            r_tail  <= r_tail + c_PTR_W'(w_n_enq);
            r_count <= r_count + c_CNT_W'(w_n_enq) - c_CNT_W'(w_n_deq);
            r_kill  <= w_kill_next;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++) begin
            if (!q.flush && (c_ENQ_CW'(i) < w_n_enq)) begin
                r_data[r_tail + c_PTR_W'(i)] <= q.enq_item[i*ITEM_W +: ITEM_W];
            end
        end
    end

    assign q.enq_ready = w_enq_ready;
    assign q.deq_valid = w_deq_valid;
    assign q.count     = r_count;

endmodule
`default_nettype wire
